// File: rtl/uart_tx.sv
// AXI-Stream to UART transmitter: FIFO-buffered words, runtime framing config, CTS flow control.
// Frame settings are snapshotted at frame start so a config write never disturbs a frame in flight.
module uart_tx #(
  parameter int unsigned BAUD_PRESCALER = 12,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned STOP_BITS      = 0,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [26:0] s_axis_config_tdata,
  input  logic        s_axis_config_tvalid,
  output logic        s_axis_config_tready,
  input  logic [8:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] tx_data_count,
  output logic        busy,
  output logic        txd,
  input  logic        ctsn
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [15:0] cfg_presc_q;
  logic [2:0]  cfg_par_q;
  logic [3:0]  cfg_size_q;
  logic        cfg_stop_q;
  logic        cfg_en_q;
  logic [15:0] new_presc;
  logic [2:0]  new_par;
  logic [3:0]  new_size;
  logic        cfg_fire;
  logic        cfg_unused;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, fifo_empty;

  logic [1:0]  cts_q;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bits_q, bits_d;
  logic [8:0]  shift_q, shift_d;
  logic        acc_q, acc_d;
  logic [15:0] fr_presc_q, fr_presc_d;
  logic [2:0]  fr_par_q, fr_par_d;
  logic [3:0]  fr_size_q, fr_size_d;
  logic        fr_stop_q, fr_stop_d;
  logic        txd_q, txd_d;
  logic        tick;
  logic        par_bit;

  assign s_axis_config_tready = (state_q == ST_IDLE);
  assign cfg_fire             = s_axis_config_tvalid & s_axis_config_tready;
  assign cfg_unused           = ^s_axis_config_tdata[26:25];

  // Out-of-range config fields fall back to safe values rather than producing odd frames.
  always_comb begin
    new_presc = s_axis_config_tdata[15:0];
    new_par   = s_axis_config_tdata[18:16];
    new_size  = s_axis_config_tdata[22:19];
    if (new_presc < 16'd2) new_presc = 16'd2;
    if (new_par > 3'd4) new_par = 3'd0;
    if (new_size < 4'd5 || new_size > 4'd9) new_size = 4'd8;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cfg_presc_q <= 16'(BAUD_PRESCALER);
      cfg_par_q   <= 3'(PARITY);
      cfg_size_q  <= 4'(BYTE_SIZE);
      cfg_stop_q  <= (STOP_BITS != 0);
      cfg_en_q    <= 1'b1;
    end else if (cfg_fire) begin
      cfg_presc_q <= new_presc;
      cfg_par_q   <= new_par;
      cfg_size_q  <= new_size;
      cfg_stop_q  <= s_axis_config_tdata[23];
      cfg_en_q    <= s_axis_config_tdata[24];
    end
  end

  assign s_axis_tready = (count_q != FULL_COUNT);
  assign push          = s_axis_tvalid & s_axis_tready;
  assign fifo_empty    = (count_q == '0);
  assign tx_data_count = {{(31-AW){1'b0}}, count_q};

  always_ff @(posedge aclk) begin
    if (push) mem_q[wptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Resets to "not clear" so nothing launches until the peer is seen ready.
  always_ff @(posedge aclk) begin
    if (!aresetn) cts_q <= 2'b11;
    else          cts_q <= {cts_q[0], ctsn};
  end

  assign tick = (cnt_q == 16'd0);

  always_comb begin
    par_bit = 1'b0;
    case (fr_par_q)
      3'd1:    par_bit = acc_q;
      3'd2:    par_bit = ~acc_q;
      3'd3:    par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
  end

  // The down-counter reloads at every bit boundary, so bit widths never accumulate error.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    fr_presc_d = fr_presc_q;
    fr_par_d   = fr_par_q;
    fr_size_d  = fr_size_q;
    fr_stop_d  = fr_stop_q;
    pop        = 1'b0;
    txd_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en_q && !fifo_empty && !cts_q[1]) begin
          pop        = 1'b1;
          shift_d    = mem_q[rptr_q];
          acc_d      = 1'b0;
          fr_presc_d = cfg_presc_q;
          fr_par_d   = cfg_par_q;
          fr_size_d  = cfg_size_q;
          fr_stop_d  = cfg_stop_q;
          cnt_d      = cfg_presc_q - 16'd1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        txd_d = 1'b0;
        if (tick) begin
          cnt_d   = fr_presc_q - 16'd1;
          bits_d  = fr_size_q - 4'd1;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        txd_d = shift_q[0];
        if (tick) begin
          cnt_d   = fr_presc_q - 16'd1;
          acc_d   = acc_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[8:1]};
          if (bits_q == 4'd0) begin
            bits_d  = {3'b000, fr_stop_q};
            state_d = (fr_par_q != 3'd0) ? ST_PAR : ST_STOP;
          end else begin
            bits_d = bits_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_PAR: begin
        txd_d = par_bit;
        if (tick) begin
          cnt_d   = fr_presc_q - 16'd1;
          bits_d  = {3'b000, fr_stop_q};
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          cnt_d = fr_presc_q - 16'd1;
          if (bits_q == 4'd0) state_d = ST_IDLE;
          else                bits_d  = bits_q - 4'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      fr_presc_q <= 16'(BAUD_PRESCALER);
      fr_par_q   <= 3'(PARITY);
      fr_size_q  <= 4'(BYTE_SIZE);
      fr_stop_q  <= (STOP_BITS != 0);
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      fr_presc_q <= fr_presc_d;
      fr_par_q   <= fr_par_d;
      fr_size_q  <= fr_size_d;
      fr_stop_q  <= fr_stop_d;
      txd_q      <= txd_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a table of framing vectors with hand-computed bit patterns,
// plus hand-written sequences for flow control, FIFO full, mid-frame config and mid-frame reset.
module tb_uart_tx;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [26:0] cfgData;
  logic        cfgValid;
  logic        cfgReady;
  logic [8:0]  sData;
  logic        sValid;
  logic        sReady;
  logic [31:0] txCount;
  logic        busy;
  logic        txd;
  logic        ctsn;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int pushCycle = 0;
  int acceptCycle = -1;

  uart_tx dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_config_tdata  (cfgData),
    .s_axis_config_tvalid (cfgValid),
    .s_axis_config_tready (cfgReady),
    .s_axis_tdata         (sData),
    .s_axis_tvalid        (sValid),
    .s_axis_tready        (sReady),
    .tx_data_count        (txCount),
    .busy                 (busy),
    .txd                  (txd),
    .ctsn                 (ctsn)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cycle <= cycle + 1;

  typedef struct {
    logic [15:0] cfgP;
    int          expP;
    logic [2:0]  par;
    logic [3:0]  size;
    logic        stop;
    logic [8:0]  data;
    logic [11:0] expBits;
    int          len;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [26:0] cfgWord(input logic [15:0] p, input logic [2:0] par,
                                          input logic [3:0] size, input logic stop, input logic en);
    return {2'b00, en, stop, size, par, p};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Each step lands 1 time unit after a rising edge, where outputs are settled.
  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [8:0] data);
    sValid = 1'b1;
    sData  = data;
    waitEdges(1);
    pushCycle = cycle;
    sValid = 1'b0;
  endtask

  task automatic applyConfig(input logic [15:0] p, input logic [2:0] par, input logic [3:0] size,
                             input logic stop, input logic en);
    cfgValid = 1'b1;
    cfgData  = cfgWord(p, par, size, stop, en);
    checkOutput("cfg_ready_idle", 32'(cfgReady), 32'd1);
    waitEdges(1);
    cfgValid = 1'b0;
  endtask

  // Called right after the pushing edge N: checks idle at N+1, start bit at N+2,
  // each bit near its middle, and that busy drops exactly p*len cycles after frame start.
  task automatic runFrame(input string tag, input int p, input logic [11:0] expBits, input int len);
    waitEdges(1);
    checkOutput({tag, "_pre_start"}, 32'(txd), 32'd1);
    waitEdges(1);
    checkOutput({tag, "_start_n2"}, 32'(txd), 32'd0);
    waitEdges((p - 1) / 2);
    for (int k = 0; k < len; k++) begin
      if (k > 0) waitEdges(p);
      checkOutput($sformatf("%s_bit%0d", tag, k), 32'(txd), 32'(expBits[k]));
    end
    waitEdges(p - 1 - (p - 1) / 2 - 1);
    checkOutput({tag, "_busy_last"}, 32'(busy), 32'd1);
    waitEdges(1);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idle_txd"}, 32'(txd), 32'd1);
  endtask

  initial begin
    int falls [4];
    int nFalls;
    logic prev;

    // Bit i of expBits is the i-th bit on the line, starting with the start bit.
    vecs[0] = '{16'd4, 4, 3'd0, 4'd8, 1'b0, 9'h055, 12'h2AA, 10};
    vecs[1] = '{16'd4, 4, 3'd1, 4'd8, 1'b0, 9'h003, 12'h406, 11};
    vecs[2] = '{16'd4, 4, 3'd2, 4'd8, 1'b0, 9'h003, 12'h606, 11};
    vecs[3] = '{16'd4, 4, 3'd3, 4'd8, 1'b0, 9'h003, 12'h606, 11};
    vecs[4] = '{16'd4, 4, 3'd4, 4'd8, 1'b0, 9'h003, 12'h406, 11};
    vecs[5] = '{16'd4, 4, 3'd2, 4'd7, 1'b1, 9'h07F, 12'h6FE, 11};
    vecs[6] = '{16'd4, 4, 3'd0, 4'd5, 1'b0, 9'h1F3, 12'h066, 7};
    vecs[7] = '{16'd6, 6, 3'd1, 4'd9, 1'b0, 9'h1A5, 12'hF4A, 12};
    vecs[8] = '{16'd1, 2, 3'd6, 4'd3, 1'b0, 9'h0A5, 12'h34A, 10};

    aresetn  = 1'b0;
    cfgData  = '0;
    cfgValid = 1'b0;
    sData    = '0;
    sValid   = 1'b0;
    ctsn     = 1'b0;

    waitEdges(3);
    checkOutput("reset_txd", 32'(txd), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_count", txCount, 32'd0);
    checkOutput("reset_tready", 32'(sReady), 32'd1);
    checkOutput("reset_cfg_tready", 32'(cfgReady), 32'd1);
    aresetn = 1'b1;
    waitEdges(3);

    for (int i = 0; i < 9; i++) begin
      applyConfig(vecs[i].cfgP, vecs[i].par, vecs[i].size, vecs[i].stop, 1'b1);
      applyStimulus(vecs[i].data);
      runFrame($sformatf("vec%0d", i), vecs[i].expP, vecs[i].expBits, vecs[i].len);
    end

    // A config write during a frame must wait for IDLE and leave the frame untouched.
    applyConfig(16'd4, 3'd0, 4'd8, 1'b0, 1'b1);
    applyStimulus(9'h055);
    acceptCycle = -1;
    fork
      runFrame("midcfg", 4, 12'h2AA, 10);
      begin
        waitEdges(3);
        cfgValid = 1'b1;
        cfgData  = cfgWord(16'd6, 3'd0, 4'd8, 1'b0, 1'b1);
        checkOutput("midcfg_tready_low", 32'(cfgReady), 32'd0);
        for (int i = 0; i < 100; i++) begin
          if (cfgReady) begin
            acceptCycle = cycle + 1;
            break;
          end
          waitEdges(1);
        end
        waitEdges(1);
        cfgValid = 1'b0;
      end
    join
    checkOutput("midcfg_accept_cycle", 32'(acceptCycle), 32'(pushCycle + 42));
    applyStimulus(9'h055);
    runFrame("newcfg_p6", 6, 12'h2AA, 10);

    // Flow control: queued words wait for CTS, then go out with a single idle clock between frames.
    applyConfig(16'd4, 3'd0, 4'd8, 1'b0, 1'b1);
    ctsn = 1'b1;
    waitEdges(3);
    applyStimulus(9'h0FF);
    applyStimulus(9'h0FF);
    applyStimulus(9'h0FF);
    checkOutput("cts_hold_count", txCount, 32'd3);
    waitEdges(20);
    checkOutput("cts_hold_txd", 32'(txd), 32'd1);
    checkOutput("cts_hold_busy", 32'(busy), 32'd0);
    checkOutput("cts_hold_count_late", txCount, 32'd3);
    ctsn   = 1'b0;
    prev   = 1'b1;
    nFalls = 0;
    for (int i = 0; i < 300; i++) begin
      waitEdges(1);
      if (prev && !txd && nFalls < 4) begin
        falls[nFalls] = cycle;
        nFalls++;
      end
      prev = txd;
    end
    checkOutput("cts_frames", 32'(nFalls), 32'd3);
    if (nFalls >= 3) begin
      checkOutput("cts_gap1", 32'(falls[1] - falls[0]), 32'd41);
      checkOutput("cts_gap2", 32'(falls[2] - falls[1]), 32'd41);
    end
    checkOutput("cts_drained_count", txCount, 32'd0);
    checkOutput("cts_drained_busy", 32'(busy), 32'd0);

    // With tx_en low the FIFO fills to depth and then refuses further words.
    applyConfig(16'd4, 3'd0, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(9'(i));
    checkOutput("full_count", txCount, 32'd16);
    checkOutput("full_tready", 32'(sReady), 32'd0);
    sValid = 1'b1;
    sData  = 9'h1AA;
    waitEdges(1);
    sValid = 1'b0;
    checkOutput("full_reject_count", txCount, 32'd16);
    checkOutput("full_txd_idle", 32'(txd), 32'd1);
    checkOutput("full_busy", 32'(busy), 32'd0);

    // Enabling starts draining; a reset mid-DATA aborts the frame and flushes the FIFO.
    applyConfig(16'd4, 3'd0, 4'd8, 1'b0, 1'b1);
    waitEdges(8);
    checkOutput("drain_busy", 32'(busy), 32'd1);
    checkOutput("drain_count", txCount, 32'd15);
    aresetn = 1'b0;
    waitEdges(1);
    checkOutput("midrst_txd", 32'(txd), 32'd1);
    checkOutput("midrst_count", txCount, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_tready", 32'(sReady), 32'd1);
    aresetn = 1'b1;
    waitEdges(3);
    applyStimulus(9'h055);
    runFrame("resume_p12", 12, 12'h2AA, 10);
    waitEdges(10);
    checkOutput("resume_flushed_busy", 32'(busy), 32'd0);
    checkOutput("resume_flushed_count", txCount, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
